// File: rtl/parking_gate_arbiter.sv
// Car park lane arbiter: serialises entry/exit requests onto the parking buffer and car counter,
// allocates and validates Car_Id slots, and times the barrier gate after each granted transaction.
module parking_gate_arbiter #(
  parameter int unsigned NUM_SLOTS   = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned GATE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entry_req,
  input  logic                 exit_req,
  input  logic [ID_W-1:0]      exit_id,
  output logic                 entry_ack,
  output logic                 exit_ack,
  output logic                 deny,
  output logic [ID_W-1:0]      assigned_id,
  output logic                 write_enable,
  output logic                 read_enable,
  output logic [ID_W-1:0]      buf_car_id,
  output logic                 count_up,
  output logic                 count_down,
  output logic                 gate_open,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic                 is_full,
  output logic                 is_empty
);

  localparam int unsigned CntW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StEntryWr, StExitRd, StDeny, StGate} state_e;
  typedef enum logic {GrantEntry, GrantExit} grant_e;

  state_e              state_q, state_d;
  grant_e              last_q, last_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ID_W-1:0]     free_id;
  logic                pick_entry, pick_exit;

  logic                entry_ack_d, exit_ack_d, deny_d;
  logic                write_enable_d, read_enable_d, count_up_d, count_down_d, gate_open_d;
  logic [ID_W-1:0]     assigned_id_d, buf_car_id_d;
  logic [NUM_SLOTS-1:0] occ_d;

  // Lowest-index free slot; scanning downwards leaves the smallest index last.
  always_comb begin
    free_id = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupied[i]) free_id = ID_W'(i);
    end
  end

  // Round-robin: on a tie the requester opposite to the last selection wins.
  assign pick_entry = entry_req && (!exit_req || (last_q == GrantExit));
  assign pick_exit  = exit_req && !pick_entry;

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    cnt_d          = cnt_q;
    occ_d          = occupied;
    assigned_id_d  = assigned_id;
    buf_car_id_d   = buf_car_id;
    entry_ack_d    = 1'b0;
    exit_ack_d     = 1'b0;
    deny_d         = 1'b0;
    write_enable_d = 1'b0;
    read_enable_d  = 1'b0;
    count_up_d     = 1'b0;
    count_down_d   = 1'b0;
    gate_open_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_entry) begin
          last_d      = GrantEntry;
          entry_ack_d = 1'b1;
          if (is_full) begin
            state_d = StDeny;
            deny_d  = 1'b1;
          end else begin
            state_d        = StEntryWr;
            write_enable_d = 1'b1;
            count_up_d     = 1'b1;
            assigned_id_d  = free_id;
            buf_car_id_d   = free_id;
          end
        end else if (pick_exit) begin
          last_d     = GrantExit;
          exit_ack_d = 1'b1;
          if (!occupied[exit_id]) begin
            state_d = StDeny;
            deny_d  = 1'b1;
          end else begin
            state_d       = StExitRd;
            read_enable_d = 1'b1;
            count_down_d  = 1'b1;
            buf_car_id_d  = exit_id;
          end
        end
      end
      StEntryWr: begin
        occ_d[buf_car_id] = 1'b1;
        state_d           = StGate;
        gate_open_d       = 1'b1;
        cnt_d             = CntW'(GATE_CYCLES - 1);
      end
      StExitRd: begin
        occ_d[buf_car_id] = 1'b0;
        state_d           = StGate;
        gate_open_d       = 1'b1;
        cnt_d             = CntW'(GATE_CYCLES - 1);
      end
      StDeny: begin
        state_d = StIdle;
      end
      StGate: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d       = cnt_q - 1'b1;
          gate_open_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      last_q       <= GrantExit;
      cnt_q        <= '0;
      occupied     <= '0;
      is_full      <= 1'b0;
      is_empty     <= 1'b1;
      assigned_id  <= '0;
      buf_car_id   <= '0;
      entry_ack    <= 1'b0;
      exit_ack     <= 1'b0;
      deny         <= 1'b0;
      write_enable <= 1'b0;
      read_enable  <= 1'b0;
      count_up     <= 1'b0;
      count_down   <= 1'b0;
      gate_open    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      occupied     <= occ_d;
      is_full      <= &occ_d;
      is_empty     <= ~|occ_d;
      assigned_id  <= assigned_id_d;
      buf_car_id   <= buf_car_id_d;
      entry_ack    <= entry_ack_d;
      exit_ack     <= exit_ack_d;
      deny         <= deny_d;
      write_enable <= write_enable_d;
      read_enable  <= read_enable_d;
      count_up     <= count_up_d;
      count_down   <= count_down_d;
      gate_open    <= gate_open_d;
    end
  end

endmodule

// File: doc/parking_gate_arbiter.md
Name: parking_gate_arbiter

Overview:
- Sequences entry and exit requests for the car park and serialises them onto the shared parking buffer write/read port and the car counter.
- Allocates a free Car_Id slot on entry and validates the Car_Id on exit.
- Drives a gate-open timer after each successful transaction.
- Sits between the lane sensors and the buffer/counter datapath, in place of the free-running FSM.

Parameters:
- NUM_SLOTS, 4, number of parking slots; one occupancy bit each.
- ID_W, 2, Car_Id width; clog2(NUM_SLOTS).
- GATE_CYCLES, 8, cycles gate_open stays high after a granted transaction; must be ≥1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- entry_req  in  1  entry lane request; level, held until entry_ack
- exit_req  in  1  exit lane request; level, held until exit_ack
- exit_id  in  ID_W  Car_Id presented with exit_req; stable while exit_req is high
- entry_ack  out  1  one-cycle entry completion pulse
- exit_ack  out  1  one-cycle exit completion pulse
- deny  out  1  high with an ack when the request is refused
- assigned_id  out  ID_W  slot granted to the entering car; valid with entry_ack when deny=0; holds its value until the next grant
- write_enable  out  1  buffer write strobe (store entry time)
- read_enable  out  1  buffer read strobe (fetch entry time)
- buf_car_id  out  ID_W  buffer address; valid with write_enable/read_enable
- count_up  out  1  counter increment strobe
- count_down  out  1  counter decrement strobe
- gate_open  out  1  barrier open
- occupied  out  NUM_SLOTS  slot occupancy bitmap
- is_full  out  1  all occupied bits set
- is_empty  out  1  no occupied bits set

Behaviour:
- Reset (reset=0 at a rising clk edge):
  - State goes to IDLE.
  - occupied=0, so is_empty=1 and is_full=0.
  - All strobes, acks, deny and gate_open are 0.
  - assigned_id=0, buf_car_id=0, last_grant=EXIT.
  - Reset mid-transaction or mid-gate aborts immediately; no strobe completes.
- All outputs are registered (Moore); none depends combinationally on the inputs.
- States: IDLE, ENTRY_WR, EXIT_RD, DENY, GATE.
- IDLE:
  - Requests are sampled only in IDLE.
  - With only one request high, that request is chosen.
  - With both high, round-robin: the requester opposite to last_grant wins. After reset, entry wins first because last_grant=EXIT.
  - last_grant is updated on every selection, including denied ones.
- Entry selected:
  - If is_full, go to DENY with entry_ack=1 and deny=1.
  - Otherwise go to ENTRY_WR.
- ENTRY_WR (exactly 1 cycle):
  - write_enable=1, count_up=1, entry_ack=1.
  - buf_car_id and assigned_id are set to the lowest-index free slot.
  - The occupied bit for that slot sets on exit from the state.
  - Next state is GATE.
- Exit selected:
  - If occupied[exit_id]=0, go to DENY with exit_ack=1 and deny=1.
  - Otherwise go to EXIT_RD.
- EXIT_RD (exactly 1 cycle):
  - read_enable=1, count_down=1, exit_ack=1, buf_car_id=exit_id.
  - occupied[exit_id] clears on exit from the state.
  - Next state is GATE.
- DENY: 1 cycle; ack and deny high; then IDLE. No strobes, no gate.
- GATE:
  - gate_open=1 for exactly GATE_CYCLES cycles, counted with an internal down-counter.
  - Then IDLE. Requests are ignored while in GATE.
- Latency: a request high at edge N (state IDLE) gives ack high during cycle N+1. gate_open is high for cycles N+2 .. N+1+GATE_CYCLES. IDLE is back at cycle N+2+GATE_CYCLES.
- Handshake: the requester deasserts its req at the edge where it sees ack. That is the same edge at which the block leaves the ack state, so a single request is never served twice.
- Strobe exclusivity: write_enable and read_enable are never both high. count_up and count_down are never both high. Each strobe is exactly 1 cycle wide.
- is_full and is_empty are derived from occupied and are registered in the same cycle as the occupied update.

Test Plan:
- Reset, then entry_req pulse → entry_ack, write_enable, count_up and assigned_id=0 one cycle after sampling; gate_open high 8 cycles; occupied=0001.
- Four entries, then a fifth → ids 0,1,2,3 granted and is_full=1; the fifth gets entry_ack with deny=1, no write_enable, no gate_open, occupied stays 1111.
- With occupied=1111, exit_id=2 → read_enable, count_down, exit_ack, buf_car_id=2; occupied=1011. A following entry is granted assigned_id=2 (lowest free slot).
- Exit with exit_id=3 while occupied=0001 → exit_ack with deny=1, no read_enable, occupied unchanged. Exit on an empty park behaves the same.
- entry_req and exit_req raised in the same cycle, repeatedly → grants alternate entry, exit, entry… starting with entry after reset. Requests asserted during GATE are not acked until IDLE.
- reset=0 in the 3rd gate_open cycle → next cycle gate_open=0, occupied=0, state IDLE; an entry request afterwards is served normally with assigned_id=0.
